// File: rtl/playback_time_bcd_counter.sv
// MM:SS BCD playback timer: a once-per-second prescaler drives an up/down digit chain.
// The down count saturates at 00:00. Define PAUSE_BLINK_EN to make the blank mask flash while paused.
module playback_time_bcd_counter #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       dir,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       tick,
    output logic       wrap,
    output logic       at_zero,
    output logic [3:0] blank
);

    localparam int unsigned    PW        = (CLK_FREQ_HZ > 32'd1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_TC  = PW'(CLK_FREQ_HZ - 32'd1);
    localparam logic [PW-1:0]  PRESC_ONE = PW'(32'd1);
    localparam logic [15:0]    TIME_ZERO = 16'h0000;
    localparam logic [15:0]    TIME_MAX  = 16'h9959;

    // Digit order in the packed time word: {min_tens, min_ones, sec_tens, sec_ones}.
    // The >= compares pull any out-of-range digit back into range on the next update.
    function automatic logic [15:0] time_inc(input logic [15:0] t);
        logic [3:0] so, st, mo, mt;
        {mt, mo, st, so} = t;
        if (so >= 4'd9) begin
            so = 4'd0;
            if (st >= 4'd5) begin
                st = 4'd0;
                if (mo >= 4'd9) begin
                    mo = 4'd0;
                    if (mt >= 4'd9) begin
                        mt = 4'd0;
                    end else begin
                        mt = mt + 4'd1;
                    end
                end else begin
                    mo = mo + 4'd1;
                end
            end else begin
                st = st + 4'd1;
            end
        end else begin
            so = so + 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    function automatic logic [15:0] time_dec(input logic [15:0] t);
        logic [3:0] so, st, mo, mt;
        {mt, mo, st, so} = t;
        if (t == TIME_ZERO) begin
            so = 4'd0;
        end else if (so == 4'd0) begin
            so = 4'd9;
            if (st == 4'd0) begin
                st = 4'd5;
                if (mo == 4'd0) begin
                    mo = 4'd9;
                    if (mt == 4'd0) begin
                        mt = 4'd0;
                    end else begin
                        mt = mt - 4'd1;
                    end
                end else begin
                    mo = mo - 4'd1;
                end
            end else begin
                st = st - 4'd1;
            end
        end else begin
            so = so - 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   time_q, time_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          at_zero_q, at_zero_d;

    // Prescaler and digit next-state; clear overrides everything, including a terminal count.
    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            presc_d = {PW{1'b0}};
            time_d  = TIME_ZERO;
        end else if (run) begin
            if (presc_q >= PRESC_TC) begin
                presc_d = {PW{1'b0}};
                tick_d  = 1'b1;
                if (dir) begin
                    time_d = time_dec(time_q);
                end else begin
                    time_d = time_inc(time_q);
                    wrap_d = (time_q == TIME_MAX);
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else begin
            presc_d = presc_q;
        end
        at_zero_d = (time_d == TIME_ZERO);
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= {PW{1'b0}};
            time_q    <= TIME_ZERO;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            at_zero_q <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            time_q    <= time_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            at_zero_q <= at_zero_d;
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = time_q;
    assign tick    = tick_q;
    assign wrap    = wrap_q;
    assign at_zero = at_zero_q;

`ifdef PAUSE_BLINK_EN
    localparam int unsigned   HALF     = CLK_FREQ_HZ / 32'd2;
    localparam int unsigned   HW       = (HALF > 32'd1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] HALF_TC  = HW'(HALF - 32'd1);
    localparam logic [HW-1:0] HALF_ONE = HW'(32'd1);

    logic [HW-1:0] half_q, half_d;
    logic [3:0]    blank_q, blank_d;

    // Half-second blink timer, only free-running while paused on a non-zero time.
    always_comb begin
        half_d  = half_q;
        blank_d = blank_q;
        if (run || clear || at_zero_q) begin
            half_d  = {HW{1'b0}};
            blank_d = 4'h0;
        end else if (half_q >= HALF_TC) begin
            half_d  = {HW{1'b0}};
            blank_d = ~blank_q;
        end else begin
            half_d  = half_q + HALF_ONE;
            blank_d = blank_q;
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_q  <= {HW{1'b0}};
            blank_q <= 4'h0;
        end else begin
            half_q  <= half_d;
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 4'h0;
`endif

endmodule

// File: tb/tb_playback_time_bcd_counter.sv
// Randomised scoreboard bench for playback_time_bcd_counter; the reference keeps time as whole seconds.
module tb_playback_time_bcd_counter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, blank;
    logic       tick, wrap, at_zero;

    playback_time_bcd_counter #(.CLK_FREQ_HZ(N)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .clear(clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .tick(tick), .wrap(wrap), .at_zero(at_zero), .blank(blank)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    string       cur = "reset";
    logic [22:0] exp_q[$];

    int         m_secs, m_phase, m_hcnt;
    bit         m_tick, m_wrap, m_zero;
    logic [3:0] m_blank;

    function automatic logic [22:0] dut_out();
        return {min_tens, min_ones, sec_tens, sec_ones, tick, wrap, at_zero, blank};
    endfunction

    function automatic logic [22:0] model_out();
        int mm, ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m_tick, m_wrap, m_zero, m_blank};
    endfunction

    task automatic model_reset();
        m_secs = 0; m_phase = 0; m_hcnt = 0;
        m_tick = 1'b0; m_wrap = 1'b0; m_zero = 1'b1; m_blank = 4'h0;
    endtask

    task automatic model_step(input bit r, input bit d, input bit c);
        bit prev_zero;
        prev_zero = m_zero;
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (c) begin
            m_secs = 0;
            m_phase = 0;
        end else if (r) begin
            if (m_phase == N - 1) begin
                m_phase = 0;
                m_tick = 1'b1;
                if (d) begin
                    if (m_secs > 0) m_secs = m_secs - 1;
                end else begin
                    m_wrap = (m_secs == 5999);
                    m_secs = (m_secs + 1) % 6000;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
        m_zero = (m_secs == 0);
`ifdef PAUSE_BLINK_EN
        if (r || c || prev_zero) begin
            m_hcnt = 0;
            m_blank = 4'h0;
        end else if (m_hcnt == N / 2 - 1) begin
            m_hcnt = 0;
            m_blank = ~m_blank;
        end else begin
            m_hcnt = m_hcnt + 1;
        end
`endif
    endtask

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got digits=%h t/w/z=%b%b%b blank=%h, expected digits=%h t/w/z=%b%b%b blank=%h",
                     name, act[22:7], act[6], act[5], act[4], act[3:0],
                     exp[22:7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic cyc(input bit r, input bit d, input bit c);
        @(negedge clk);
        run = r; dir = d; clear = c;
        model_step(r, d, c);
        exp_q.push_back(model_out());
    endtask

    // Let the last driven edge land, then check the displayed time against a fixed value.
    task automatic expect_time(input string name, input logic [15:0] t);
        @(posedge clk);
        #2;
        check(name, 23'({min_tens, min_ones, sec_tens, sec_ones}), 23'(t));
    endtask

    // Monitor: every edge that had stimulus queued is compared just after it.
    initial begin
        logic [22:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(cur, dut_out(), e);
            end
        end
    end

    initial begin
        int pause_left;
        bit r, d, c;
        model_reset();
        #2 reset_n = 1'b0;
        #1 check("reset", dut_out(), model_out());
        @(negedge clk);
        reset_n = 1'b1;

        cur = "count_up";
        repeat (12) cyc(1'b1, 1'b0, 1'b0);
        expect_time("count_up_0003", 16'h0003);

        cur = "preload_wrap";
        repeat (5995 * N) cyc(1'b1, 1'b0, 1'b0);
        expect_time("preload_9958", 16'h9958);
        repeat (8) cyc(1'b1, 1'b0, 1'b0);
        expect_time("wrap_0000", 16'h0000);

        cur = "count_down";
        repeat (60 * N) cyc(1'b1, 1'b0, 1'b0);
        expect_time("to_0100", 16'h0100);
        repeat (N) cyc(1'b1, 1'b1, 1'b0);
        expect_time("borrow_0059", 16'h0059);
        repeat (61 * N) cyc(1'b1, 1'b1, 1'b0);
        expect_time("saturate_0000", 16'h0000);

        cur = "pause";
        repeat (N + 2) cyc(1'b1, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0);
        expect_time("resume_0002", 16'h0002);

        cur = "blink";
        repeat (3 * N) cyc(1'b1, 1'b0, 1'b0);
        repeat (8) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);

        cur = "clear_on_tick";
        for (int i = 0; i < N && m_phase != N - 1; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        expect_time("clear_0000", 16'h0000);

        cur = "random";
        pause_left = 0;
        d = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (pause_left > 0) begin
                r = 1'b0;
                pause_left--;
            end else begin
                r = 1'b1;
                if ($urandom_range(0, 49) == 0) pause_left = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 29) == 0) d = ~d;
            c = ($urandom_range(0, 299) == 0);
            cyc(r, d, c);
        end

        cur = "async_reset";
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        run = 1'b0; clear = 1'b0;
        model_reset();
        #1 check("async_reset", dut_out(), model_out());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cur = "after_reset";
        repeat (2 * N + 1) cyc(1'b1, 1'b0, 1'b0);
        expect_time("after_reset_0002", 16'h0002);

        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
